uart_port_arbiter: RTL and testbench
====================================

// Module: uart_port_arbiter
// PURPOSE
//  Shares the single miniuart2 register port (rd/wr/addr/din/dout) among N_REQ CPU cores.
//  Requesters use a req/ack handshake. A round-robin FSM grants one access at a time and
//  drives one registered strobe cycle to the UART.
//  A requester can lock ownership so its multi-byte messages are not interleaved;
//  an idle-timeout breaks stale locks. Sits between the cpu_top instances and miniuart2.
// PARAMETERS
//  N_REQ        4     number of requesters (2..8)
//  DW           8     UART data width (matches UartDataWidth)
//  LOCK_TIMEOUT 1023  idle cycles after which a held lock is forcibly released (>=1)
// PORTS
//  clk          in   1        system clock (50 MHz domain)
//  rst_in       in   1        asynchronous, active-low reset
//  req_rd       in   N_REQ    per-requester read request, held until ack
//  req_wr       in   N_REQ    per-requester write request, held until ack
//  req_lock     in   N_REQ    per-requester lock-hold request
//  req_addr     in   2*N_REQ  packed register address, slice i = [2i+1:2i]
//  req_din      in   DW*N_REQ packed write data, slice i = [DW*i+DW-1:DW*i]
//  req_ack      out  N_REQ    one-cycle completion pulse, one-hot
//  req_dout     out  DW       read data, valid in the ack cycle, held until next capture
//  grant        out  N_REQ    one-hot current owner, 0 when idle
//  lock_timeout out  1        one-cycle pulse when a lock is force-released
//  uart_rd      out  1        UART read strobe (one cycle)
//  uart_wr      out  1        UART write strobe (one cycle)
//  uart_addr    out  2        UART register address
//  uart_din     out  DW       UART write data
//  uart_dout    in   DW       UART read data, valid the cycle after uart_rd
// BEHAVIOUR
//  - Reset (rst_in=0, async):
//    - All outputs are 0. State = IDLE and lock counter = 0.
//    - RR pointer = 0, so requester 0 has highest priority first.
//    - Reset mid-access drops uart_rd/uart_wr immediately. No ack is issued.
//  - FSM states: IDLE, ACCESS, CAPTURE, ACK, LOCKED. All outputs are registered.
//  - IDLE: pending = req_rd|req_wr.
//    - If pending != 0, select the first set bit scanning from rr_ptr upward with wrap.
//    - Latch grant, addr, din and op, then go to ACCESS.
//  - ACCESS (1 cycle): uart_wr=1 if req_wr[g], else uart_rd=1. uart_addr/uart_din are held from the latch.
//    - If both rd and wr are set: perform the write only; no read strobe is issued.
//  - CAPTURE (1 cycle): strobes are 0. On a read, req_dout <= uart_dout.
//  - ACK (1 cycle): req_ack[g]=1 and rr_ptr <= g+1 mod N_REQ.
//    - Next state is LOCKED if req_lock[g]=1, else IDLE. grant is cleared when entering IDLE.
//  - Latency: req asserted in cycle 0 with arbiter IDLE -> strobe cycle 1, capture cycle 2, ack cycle 3.
//  - Requester rule: drop req_rd/req_wr in the cycle after ack. IDLE/LOCKED sample one cycle after ACK, so a
//    dropped request is never re-served.
//  - LOCKED: only requester g is served; its request goes to ACCESS with counter cleared.
//    - The counter increments each cycle g has no request.
//    - If req_lock[g]=0, exit to IDLE (no pulse).
//    - If the counter reaches LOCK_TIMEOUT, exit to IDLE with lock_timeout=1 for one cycle.
//    - When lock is dropped and a request arrive together, the request is served first, then IDLE.
//    - The counter saturates and never wraps.
//  - Other requesters wait unboundedly while locked; there is no starvation guard beyond the timeout.
//  - Width: the counter is $clog2(LOCK_TIMEOUT+1) bits; rr_ptr is $clog2(N_REQ) bits and wraps from N_REQ-1 to 0.
// TESTING
//  1 Single read: req_rd[1]=1, addr=2, uart_dout=8'h5A after strobe -> uart_rd at cycle 1, addr=2, ack[1] at cycle 3,
//    req_dout=8'h5A.
//  2 Single write: req_wr[0]=1, din=8'h41 -> one uart_wr pulse with uart_din=8'h41; ack[0] at cycle 3.
//  3 Round-robin: req_wr=4'b1111 held, each requester dropping after its ack -> grants in order 0,1,2,3.
//    Re-assert all -> order restarts at 0 after 3.
//  4 Lock: req_lock[2]=1 with 3 writes from requester 2 while req_wr[0] is pending -> all 3 from 2 complete first.
//    Lock drops -> requester 0 is served.
//  5 Timeout: LOCK_TIMEOUT=16, requester 1 locked and idle -> lock_timeout pulses once 16 cycles after ACK.
//    A pending requester 3 is then granted.
//  6 Async reset during ACCESS -> uart_wr drops before the next edge; no ack.
//    After release, a pending req_rd[3] is granted with requester 0 as highest priority.

Source files
------------

// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter
// Shares the single miniuart2 register port among N_REQ CPU cores. A round-robin
// FSM grants one access at a time and issues one registered strobe to the UART.
// A requester may hold a lock so its multi-byte messages are not interleaved.
// An idle timeout breaks a stale lock.
//
// Handshake (requester side): a requester raises req_rd and/or req_wr, with
// req_addr/req_din stable, and holds them until it sees its one-cycle req_ack
// pulse. It drops the request no later than the cycle after the ack. Read data
// is on req_dout in the ack cycle and is held until the next read capture. The
// IDLE and LOCKED states sample requests only one cycle after ACK, so a request
// dropped on time is never served twice.
module uart_port_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DW           = 8,
  parameter int LOCK_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic [N_REQ-1:0]    req_rd,
  input  logic [N_REQ-1:0]    req_wr,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [2*N_REQ-1:0]  req_addr,
  input  logic [DW*N_REQ-1:0] req_din,
  output logic [N_REQ-1:0]    req_ack,
  output logic [DW-1:0]       req_dout,
  output logic [N_REQ-1:0]    grant,
  output logic                lock_timeout,
  output logic                uart_rd,
  output logic                uart_wr,
  output logic [1:0]          uart_addr,
  output logic [DW-1:0]       uart_din,
  input  logic [DW-1:0]       uart_dout,
  output logic [2:0]          dbg_state
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACCESS  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_LOCKED  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             op_wr_q, op_wr_d;
  logic [CW-1:0]    lock_cnt_q, lock_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] req_ack_q, req_ack_d;
  logic [DW-1:0]    req_dout_q, req_dout_d;
  logic             lock_timeout_q, lock_timeout_d;
  logic             uart_rd_q, uart_rd_d;
  logic             uart_wr_q, uart_wr_d;
  logic [1:0]       uart_addr_q, uart_addr_d;
  logic [DW-1:0]    uart_din_q, uart_din_d;

  logic [N_REQ-1:0] pending;
  logic             sel_valid;
  logic [PW-1:0]    sel_idx;
  int               cand;
  logic             own_req;
  logic             launch;
  logic [PW-1:0]    launch_idx;

  // Round-robin pick: first pending requester scanning upward from rr_ptr, with wrap
  always_comb begin
    pending   = req_rd | req_wr;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!sel_valid && pending[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = PW'(cand);
      end
    end
  end

  assign own_req = req_rd[owner_q] | req_wr[owner_q];

  // Next-state logic for the arbiter FSM and every registered output
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    op_wr_d        = op_wr_q;
    lock_cnt_d     = lock_cnt_q;
    grant_d        = grant_q;
    req_ack_d      = '0;
    req_dout_d     = req_dout_q;
    lock_timeout_d = 1'b0;
    uart_rd_d      = 1'b0;
    uart_wr_d      = 1'b0;
    uart_addr_d    = uart_addr_q;
    uart_din_d     = uart_din_q;
    launch         = 1'b0;
    launch_idx     = owner_q;

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          launch     = 1'b1;
          launch_idx = sel_idx;
        end
      end
      S_ACCESS: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // uart_dout is valid the cycle after the read strobe, i.e. now
        if (!op_wr_q) req_dout_d = uart_dout;
        req_ack_d[owner_q] = 1'b1;
        state_d            = S_ACK;
      end
      S_ACK: begin
        rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        if (req_lock[owner_q]) begin
          state_d    = S_LOCKED;
          lock_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      S_LOCKED: begin
        // A request from the owner wins even if the lock drops in the same cycle.
        // The counter counts idle LOCKED cycles; the exit is taken on the cycle
        // in which the count reaches LOCK_TIMEOUT, so the pulse follows it.
        if (own_req) begin
          launch     = 1'b1;
          launch_idx = owner_q;
          lock_cnt_d = '0;
        end else if (!req_lock[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
        end else if (lock_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d        = S_IDLE;
          grant_d        = '0;
          lock_timeout_d = 1'b1;
          lock_cnt_d     = CW'(LOCK_TIMEOUT);
        end else if (lock_cnt_q != CW'(LOCK_TIMEOUT)) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    // Start an access: latch the owner's operation and strobe in the next cycle.
    // A simultaneous read and write performs the write only.
    if (launch) begin
      owner_d              = launch_idx;
      grant_d              = '0;
      grant_d[launch_idx]  = 1'b1;
      op_wr_d              = req_wr[launch_idx];
      uart_wr_d            = req_wr[launch_idx];
      uart_rd_d            = ~req_wr[launch_idx];
      uart_addr_d          = req_addr[2*int'(launch_idx) +: 2];
      uart_din_d           = req_din[DW*int'(launch_idx) +: DW];
      state_d              = S_ACCESS;
    end
  end

  // State and output registers; asynchronous reset clears everything at once
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      op_wr_q        <= 1'b0;
      lock_cnt_q     <= '0;
      grant_q        <= '0;
      req_ack_q      <= '0;
      req_dout_q     <= '0;
      lock_timeout_q <= 1'b0;
      uart_rd_q      <= 1'b0;
      uart_wr_q      <= 1'b0;
      uart_addr_q    <= '0;
      uart_din_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      op_wr_q        <= op_wr_d;
      lock_cnt_q     <= lock_cnt_d;
      grant_q        <= grant_d;
      req_ack_q      <= req_ack_d;
      req_dout_q     <= req_dout_d;
      lock_timeout_q <= lock_timeout_d;
      uart_rd_q      <= uart_rd_d;
      uart_wr_q      <= uart_wr_d;
      uart_addr_q    <= uart_addr_d;
      uart_din_q     <= uart_din_d;
    end
  end

  assign req_ack      = req_ack_q;
  assign req_dout     = req_dout_q;
  assign grant        = grant_q;
  assign lock_timeout = lock_timeout_q;
  assign uart_rd      = uart_rd_q;
  assign uart_wr      = uart_wr_q;
  assign uart_addr    = uart_addr_q;
  assign uart_din     = uart_din_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed testbench for uart_port_arbiter (N_REQ=4, DW=8, LOCK_TIMEOUT=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_port_arbiter;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOCKED = 3'd4;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [3:0]  req_rd, req_wr, req_lock;
  logic [7:0]  req_addr;
  logic [31:0] req_din;
  logic [3:0]  req_ack;
  logic [7:0]  req_dout;
  logic [3:0]  grant;
  logic        lock_timeout;
  logic        uart_rd, uart_wr;
  logic [1:0]  uart_addr;
  logic [7:0]  uart_din;
  logic [7:0]  uart_dout;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  uart_port_arbiter #(.N_REQ(4), .DW(8), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst_in(rst_in),
    .req_rd(req_rd), .req_wr(req_wr), .req_lock(req_lock),
    .req_addr(req_addr), .req_din(req_din),
    .req_ack(req_ack), .req_dout(req_dout), .grant(grant),
    .lock_timeout(lock_timeout),
    .uart_rd(uart_rd), .uart_wr(uart_wr), .uart_addr(uart_addr),
    .uart_din(uart_din), .uart_dout(uart_dout),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_in = 1'b0; req_rd = '0; req_wr = '0; req_lock = '0;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; req_rd = '0; req_wr = '0; req_lock = '0;
    req_addr = '0; req_din = '0; uart_dout = '0;
    @(negedge clk);
    checks++; if (req_ack !== 4'h0) begin failures++; $display("FAIL reset_ack got=%h exp=0", req_ack); end
    checks++; if (grant !== 4'h0) begin failures++; $display("FAIL reset_grant got=%h exp=0", grant); end
    checks++; if ({uart_rd, uart_wr, lock_timeout} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {uart_rd, uart_wr, lock_timeout}); end
    checks++; if ({uart_addr, uart_din, req_dout} !== 18'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {uart_addr, uart_din, req_dout}); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rst_in = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'h0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL post_reset_idle got=%h/%0d exp=0/0", grant, dbg_state); end
  endtask

  task automatic test_single_read();
    req_rd[1] = 1'b1; req_addr[3:2] = 2'd2;
    @(negedge clk); // strobe cycle
    checks++; if (uart_rd !== 1'b1 || uart_wr !== 1'b0) begin failures++; $display("FAIL rd_strobe got=%b%b exp=10", uart_rd, uart_wr); end
    checks++; if (uart_addr !== 2'd2) begin failures++; $display("FAIL rd_addr got=%0d exp=2", uart_addr); end
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL rd_grant got=%b exp=0010", grant); end
    @(posedge clk); #1 uart_dout = 8'h5A;
    @(negedge clk); // capture cycle
    checks++; if (uart_rd !== 1'b0 || req_ack !== 4'h0) begin failures++; $display("FAIL rd_capture got=%b/%b exp=0/0000", uart_rd, req_ack); end
    @(negedge clk); // ack cycle
    checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL rd_ack got=%b exp=0010", req_ack); end
    checks++; if (req_dout !== 8'h5A) begin failures++; $display("FAIL rd_dout got=%h exp=5a", req_dout); end
    req_rd[1] = 1'b0; uart_dout = 8'h00;
    @(negedge clk);
    checks++; if (req_ack !== 4'h0 || grant !== 4'h0) begin failures++; $display("FAIL rd_done got=%b/%b exp=0000/0000", req_ack, grant); end
  endtask

  task automatic test_single_write();
    req_wr[0] = 1'b1; req_din[7:0] = 8'h41;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || uart_rd !== 1'b0) begin failures++; $display("FAIL wr_strobe got=%b%b exp=01", uart_rd, uart_wr); end
    checks++; if (uart_din !== 8'h41) begin failures++; $display("FAIL wr_din got=%h exp=41", uart_din); end
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL wr_grant got=%b exp=0001", grant); end
    @(negedge clk);
    checks++; if (uart_wr !== 1'b0) begin failures++; $display("FAIL wr_single_pulse got=%b exp=0", uart_wr); end
    @(negedge clk);
    checks++; if (req_ack !== 4'b0001) begin failures++; $display("FAIL wr_ack got=%b exp=0001", req_ack); end
    checks++; if (req_dout !== 8'h5A) begin failures++; $display("FAIL wr_dout_held got=%h exp=5a", req_dout); end
    req_wr[0] = 1'b0;
    @(negedge clk);
    checks++; if (req_ack !== 4'h0 || uart_wr !== 1'b0) begin failures++; $display("FAIL wr_done got=%b/%b exp=0000/0", req_ack, uart_wr); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset(); // pointer was 1; reset must bring it back to 0
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) req_din[8*i +: 8] = 8'h10 + 8'(i);
      req_wr = 4'hF;
      for (int i = 0; i < 4; i++) begin
        exp_g = 4'b0001 << i;
        @(negedge clk);
        checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant round=%0d got=%b exp=%b", r, grant, exp_g); end
        checks++; if (uart_wr !== 1'b1 || uart_din !== 8'h10 + 8'(i)) begin failures++; $display("FAIL rr_write round=%0d got=%b/%h exp=1/%h", r, uart_wr, uart_din, 8'h10 + 8'(i)); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (req_ack !== exp_g) begin failures++; $display("FAIL rr_ack round=%0d got=%b exp=%b", r, req_ack, exp_g); end
        req_wr[i] = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 4'h0) begin failures++; $display("FAIL rr_idle round=%0d got=%b exp=0000", r, grant); end
      end
    end
  endtask

  task automatic test_lock();
    req_wr[2] = 1'b1; req_lock[2] = 1'b1; req_din[23:16] = 8'hA0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++; if (grant !== 4'b0100 || uart_wr !== 1'b1) begin failures++; $display("FAIL lock_grant n=%0d got=%b/%b exp=0100/1", n, grant, uart_wr); end
      checks++; if (uart_din !== 8'hA0 + 8'(n)) begin failures++; $display("FAIL lock_din n=%0d got=%h exp=%h", n, uart_din, 8'hA0 + 8'(n)); end
      if (n == 0) begin req_wr[0] = 1'b1; req_din[7:0] = 8'h55; end
      @(negedge clk);
      @(negedge clk);
      checks++; if (req_ack !== 4'b0100) begin failures++; $display("FAIL lock_ack n=%0d got=%b exp=0100", n, req_ack); end
      req_wr[2] = 1'b0;
      @(negedge clk);
      checks++; if (dbg_state !== ST_LOCKED || grant !== 4'b0100) begin failures++; $display("FAIL lock_held n=%0d got=%0d/%b exp=4/0100", n, dbg_state, grant); end
      if (n < 2) begin req_wr[2] = 1'b1; req_din[23:16] = 8'hA0 + 8'(n + 1); end
      else req_lock[2] = 1'b0;
    end
    @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE || grant !== 4'h0 || lock_timeout !== 1'b0) begin failures++; $display("FAIL unlock_idle got=%0d/%b/%b exp=0/0000/0", dbg_state, grant, lock_timeout); end
    @(negedge clk);
    checks++; if (grant !== 4'b0001 || uart_din !== 8'h55) begin failures++; $display("FAIL unlock_next got=%b/%h exp=0001/55", grant, uart_din); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ack !== 4'b0001) begin failures++; $display("FAIL unlock_ack got=%b exp=0001", req_ack); end
    req_wr[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    req_wr[1] = 1'b1; req_lock[1] = 1'b1; req_din[15:8] = 8'h11;
    req_wr[3] = 1'b1; req_din[31:24] = 8'h33;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin failures++; $display("FAIL to_grant got=%b exp=0010", grant); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ack !== 4'b0010) begin failures++; $display("FAIL to_ack got=%b exp=0010", req_ack); end
    req_wr[1] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++; if (lock_timeout !== 1'b0 || dbg_state !== ST_LOCKED) begin failures++; $display("FAIL to_early k=%0d got=%b/%0d exp=0/4", k, lock_timeout, dbg_state); end
    end
    @(negedge clk);
    checks++; if (lock_timeout !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", lock_timeout); end
    checks++; if (grant !== 4'h0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL to_release got=%b/%0d exp=0000/0", grant, dbg_state); end
    @(negedge clk);
    checks++; if (lock_timeout !== 1'b0) begin failures++; $display("FAIL to_one_pulse got=%b exp=0", lock_timeout); end
    checks++; if (grant !== 4'b1000 || uart_wr !== 1'b1 || uart_din !== 8'h33) begin failures++; $display("FAIL to_next got=%b/%b/%h exp=1000/1/33", grant, uart_wr, uart_din); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (req_ack !== 4'b1000) begin failures++; $display("FAIL to_next_ack got=%b exp=1000", req_ack); end
    req_wr[3] = 1'b0; req_lock[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    req_wr[1] = 1'b1; req_din[15:8] = 8'h77;
    req_rd[3] = 1'b1; req_addr[7:6] = 2'd1;
    @(negedge clk);
    checks++; if (uart_wr !== 1'b1 || grant !== 4'b0010) begin failures++; $display("FAIL ar_access got=%b/%b exp=1/0010", uart_wr, grant); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (uart_wr !== 1'b0 || uart_rd !== 1'b0) begin failures++; $display("FAIL ar_strobe_drop got=%b%b exp=00", uart_rd, uart_wr); end
    checks++; if (grant !== 4'h0 || dbg_state !== ST_IDLE) begin failures++; $display("FAIL ar_state got=%b/%0d exp=0000/0", grant, dbg_state); end
    req_wr[1] = 1'b0;
    @(negedge clk);
    checks++; if (req_ack !== 4'h0) begin failures++; $display("FAIL ar_no_ack got=%b exp=0000", req_ack); end
    rst_in = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'b1000 || uart_rd !== 1'b1 || uart_addr !== 2'd1) begin failures++; $display("FAIL ar_regrant got=%b/%b/%0d exp=1000/1/1", grant, uart_rd, uart_addr); end
    checks++; if (req_ack !== 4'h0) begin failures++; $display("FAIL ar_no_stale_ack got=%b exp=0000", req_ack); end
    @(posedge clk); #1 uart_dout = 8'hC3;
    @(negedge clk);
    checks++; if (req_ack !== 4'h0) begin failures++; $display("FAIL ar_capture got=%b exp=0000", req_ack); end
    @(negedge clk);
    checks++; if (req_ack !== 4'b1000 || req_dout !== 8'hC3) begin failures++; $display("FAIL ar_ack got=%b/%h exp=1000/c3", req_ack, req_dout); end
    req_rd[3] = 1'b0; uart_dout = 8'h00;
    @(negedge clk);
    checks++; if (grant !== 4'h0) begin failures++; $display("FAIL ar_done got=%b exp=0000", grant); end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_lock();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
